mips_dmem_arbiter: RTL and testbench
====================================

// Module: mips_dmem_arbiter
// PURPOSE
//  Shares one data-memory port between the core's load/store path (port C) and
//  a loader/debug DMA requester (port D). Multi-cycle memory latency; core is
//  frozen through c_stall (PC/regfile write-enable gating) until its access ends.
//  Sits between mips_core's data-memory connection and the data memory.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width
//  MEM_LAT  2   memory access cycles per transfer, legal range 1..15
// PORTS
//  clock     in   1   system clock, rising edge
//  reset_n   in   1   asynchronous, active-low reset
//  c_req     in   1   core request, level, held until c_done
//  c_we      in   1   core write (1) / read (0)
//  c_addr    in   AW  core byte address
//  c_wdata   in   DW  core write data
//  c_rdata   out  DW  core read data, registered, valid when c_done=1
//  c_done    out  1   one-cycle completion pulse to core
//  c_stall   out  1   c_req & ~c_done (combinational), freezes core PC
//  d_req/d_we/d_addr/d_wdata/d_rdata/d_done: same as port C, for DMA side
//  m_re      out  1   memory read enable
//  m_we      out  1   memory write enable
//  m_addr    out  AW  memory address
//  m_wdata   out  DW  memory write data
//  m_rdata   in   DW  memory read data, valid in last BUSY cycle
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=C, all outputs 0, rdata regs 0, m_re/m_we drop
//    immediately on reset_n low, including mid-access; the access is abandoned.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: on an edge with any req high, pick the winner, latch we/addr/wdata
//    and owner, load cnt=MEM_LAT-1, go BUSY. No req: stay IDLE, m_* = 0.
//  - Arbitration: only one requester high -> it wins. Both high -> the port
//    other than the last-served port wins (round-robin). After reset the
//    core wins the first tie.
//  - BUSY: m_addr/m_wdata come from the latched regs. m_re=~we_l, m_we=we_l,
//    both held for all MEM_LAT cycles. cnt decrements each edge. When cnt==0,
//    the edge captures m_rdata into the owner's rdata reg (reads only),
//    sets rr_ptr to the other port, and moves to DONE.
//  - DONE: owner's done=1 for exactly this cycle, m_* = 0, then IDLE.
//  - Latency: req accepted at edge k -> done high in the cycle after edge
//    k+MEM_LAT. Peak throughput is 1 access per MEM_LAT+2 cycles.
//  - Requests are never re-sampled in BUSY/DONE. If a requester drops req
//    mid-access, the access still completes and done still pulses; writes
//    are not aborted.
//  - Req still high in the IDLE cycle after done = a new access, arbitrated
//    normally.
//  - Non-owner rdata holds its last value. Write accesses leave rdata unchanged.
//  - Addresses pass through unmodified; no alignment checks.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: port C always wins ties. rr_ptr is not
//    implemented. D can be starved by continuous core traffic.
//  Not defined (default): round-robin as above.
// TESTING
//  1 reset_n=0 mid-BUSY write -> m_we=0 same cycle; after release
//    state IDLE, c_done=d_done=0, c_rdata=0.
//  2 MEM_LAT=2, memory preloaded 0xDEADBEEF @0x40; c_req read 0x40 at edge 1
//    -> m_re=1 in cycles 1-2, c_done=1 in cycle 3 only, c_rdata=0xDEADBEEF,
//    c_stall=1 in cycles 0-2.
//  3 c_req and d_req both high from reset with reads, held across done
//    -> grants alternate C,D,C,D. Each done is 4 cycles apart at MEM_LAT=2.
//  4 d_req write 0x12345678 @0x80, then c_req read @0x80
//    -> c_rdata=0x12345678; m_we high exactly MEM_LAT cycles.
//  5 c_req dropped in the first BUSY cycle of a write
//    -> write still lands and c_done pulses once. No second access follows.
//  6 ARB_FIXED_PRIO_EN, both reqs held high for 20 cycles
//    -> only c_done pulses and d_done stays 0; with the macro undefined,
//    d_done pulses 2+ times.

Source files
------------

// File: rtl/mips_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// mips_dmem_arbiter
//
// Shares one data-memory port between the core load/store path (port C) and a
// loader/debug DMA requester (port D). Each granted access holds the memory
// strobes for MEM_LAT cycles. The owner then gets a one-cycle done pulse, and
// one IDLE cycle follows before the next grant. A requester is frozen through
// its stall output (req & ~done) until its own access has finished.
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN  defined     : port C always wins a tie and no
//                                    round-robin pointer is built. D can be
//                                    starved by back-to-back core traffic.
//                      not defined : round-robin. On a tie the port that was
//                                    not served last wins. C wins the first
//                                    tie after reset.
//
// Parameters:
//   AW       address width
//   DW       data width
//   MEM_LAT  memory cycles per transfer, legal range 1..15
//
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   c_req/d_req         level request, held by the requester until its done
//   c_we/d_we           1 = write, 0 = read
//   c_addr/d_addr       byte address, passed through unmodified
//   c_wdata/d_wdata     write data
//   c_rdata/d_rdata     registered read data, valid while done is high
//   c_done/d_done       one-cycle completion pulse
//   c_stall/d_stall     req & ~done, combinational; freezes the requester
//   m_re/m_we           memory read/write enables, registered
//   m_addr/m_wdata      memory address and write data, registered
//   m_rdata             memory read data, valid in the last BUSY cycle
// -----------------------------------------------------------------------------
module mips_dmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clock,
    input  logic          reset_n,

    // core side (port C)
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_done,
    output logic          c_stall,

    // DMA side (port D)
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          d_stall,

    // memory side
    output logic          m_re,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    // Four bits cover the whole legal MEM_LAT range. The counter is loaded
    // with MEM_LAT-1 and counts down to zero.
    localparam int          CW       = 4;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

    state_e          state;
    port_e           owner;
    port_e           winner;
    logic [CW-1:0]   cnt;

`ifndef ARB_FIXED_PRIO_EN
    // Port that wins the next tie. It always points at the port that was not
    // served last.
    port_e           rr_ptr;
`endif

    // -------------------------------------------------------------------------
    // Arbitration. This is only used on an IDLE edge. Requests are not looked
    // at again until the FSM is back in IDLE.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: give every combinational output a default first. Then no path
        // through the block leaves it unassigned, and no latch is inferred.
        winner = PORT_C;
        if (c_req && d_req) begin
`ifdef ARB_FIXED_PRIO_EN
            winner = PORT_C;
`else
            winner = rr_ptr;
`endif
        end else if (d_req) begin
            winner = PORT_D;
        end
    end

    // -------------------------------------------------------------------------
    // Main FSM: IDLE -> BUSY (MEM_LAT cycles) -> DONE (1 cycle) -> IDLE.
    //
    // The m_* outputs also serve as the latched copy of the granted request.
    // They are loaded on the grant edge, held through BUSY and cleared on the
    // last BUSY edge. In the final BUSY cycle, m_we therefore still tells
    // whether read data has to be captured.
    //
    // Because every output is a flop with asynchronous reset, m_re and m_we
    // drop as soon as reset_n falls, even in the middle of an access.
    // -------------------------------------------------------------------------
    // NOTE: state and outputs in clocked blocks use non-blocking assignment
    // (<=). All flops then update together at the edge, and no read/write
    // race occurs between blocks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            owner   <= PORT_C;
            cnt     <= '0;
            m_re    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            c_rdata <= '0;
            d_rdata <= '0;
            c_done  <= 1'b0;
            d_done  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr  <= PORT_C;
`endif
        end else begin
            // Done is a single-cycle pulse. The DONE branch below is the only
            // branch that can keep it high, and only for one cycle.
            c_done <= 1'b0;
            d_done <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (c_req || d_req) begin
                        owner <= winner;
                        cnt   <= CNT_LOAD;
                        state <= S_BUSY;
                        if (winner == PORT_D) begin
                            m_re    <= ~d_we;
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                        end else begin
                            m_re    <= ~c_we;
                            m_we    <= c_we;
                            m_addr  <= c_addr;
                            m_wdata <= c_wdata;
                        end
                    end
                end

                S_BUSY: begin
                    if (cnt == '0) begin
                        // Last BUSY cycle: m_rdata is valid now. Only a read
                        // updates the owner's data register. The register of
                        // the other port keeps its value.
                        if (!m_we) begin
                            if (owner == PORT_D) begin
                                d_rdata <= m_rdata;
                            end else begin
                                c_rdata <= m_rdata;
                            end
                        end
                        if (owner == PORT_D) begin
                            d_done <= 1'b1;
                        end else begin
                            c_done <= 1'b1;
                        end
`ifndef ARB_FIXED_PRIO_EN
                        rr_ptr  <= (owner == PORT_D) ? PORT_C : PORT_D;
`endif
                        m_re    <= 1'b0;
                        m_we    <= 1'b0;
                        m_addr  <= '0;
                        m_wdata <= '0;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_DONE: begin
                    // A req that is still high here is not a grant. It is
                    // looked at as a new access on the IDLE edge after this.
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall is combinational, so a requester is released in its done cycle.
    assign c_stall = c_req & ~c_done;
    assign d_stall = d_req & ~d_done;

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips_dmem_arbiter
//
// Self-checking bench for mips_dmem_arbiter with MEM_LAT = 2.
//
// The bench contains a small word memory that the DUT drives. It also contains
// a transaction-level reference model. The model holds one granted access and
// tracks how many cycles old that access is. It owns a copy of the memory, and
// from these it works out every DUT output. A compare process checks all
// outputs against the model on every falling edge. Directed sequences add
// literal expectations, and randomized traffic then exercises the arbiter.
// -----------------------------------------------------------------------------
module tb_mips_dmem_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MEM_LAT = 2;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;

    logic          c_req   = 1'b0;
    logic          c_we    = 1'b0;
    logic [AW-1:0] c_addr  = '0;
    logic [DW-1:0] c_wdata = '0;
    logic [DW-1:0] c_rdata;
    logic          c_done;
    logic          c_stall;

    logic          d_req   = 1'b0;
    logic          d_we    = 1'b0;
    logic [AW-1:0] d_addr  = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          d_stall;

    logic          m_re;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mips_dmem_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .c_req   (c_req),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_rdata (c_rdata),
        .c_done  (c_done),
        .c_stall (c_stall),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_done  (d_done),
        .d_stall (d_stall),
        .m_re    (m_re),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Contents that both memories start with. Word 0x40 holds 0xDEADBEEF.
    function automatic logic [DW-1:0] mem_init(input int i);
        if (i == 16) return 32'hDEADBEEF;
        return 32'hA5A50000 | DW'(i);
    endfunction

    // ---------------------------------------------------------------- memory
    logic [DW-1:0] dev_mem [0:63];
    bit            dev_init = 1'b0;

    assign m_rdata = dev_mem[m_addr[7:2]];

    always @(negedge clock) begin
        if (!dev_init) begin
            for (int i = 0; i < 64; i++) dev_mem[i] <= mem_init(i);
            dev_init <= 1'b1;
        end else if (m_we) begin
            dev_mem[m_addr[7:2]] <= m_wdata;
        end
    end

    // ------------------------------------------------------- reference model
    // At most one granted access exists at a time. mdl_age counts cycles
    // since the grant. Ages 0..MEM_LAT-1 drive memory, age MEM_LAT is the
    // done cycle, and one free cycle follows.
    bit            mdl_busy;
    int            mdl_age;
    bit            mdl_owner_d;
    bit            mdl_we;
    logic [AW-1:0] mdl_addr;
    logic [DW-1:0] mdl_wdata;
    int            last_served;       // 0 none, 1 core, 2 DMA
    logic [DW-1:0] exp_c_rdata;
    logic [DW-1:0] exp_d_rdata;
    logic [DW-1:0] ref_mem [0:63];
    bit            ref_init = 1'b0;

    function automatic bit pick_d(input logic cr, input logic dr, input int last);
        if (cr && dr) begin
`ifdef ARB_FIXED_PRIO_EN
            return (last < 0);
`else
            return (last == 1);
`endif
        end
        return dr;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mdl_busy    <= 1'b0;
            mdl_age     <= 0;
            last_served <= 0;
            exp_c_rdata <= '0;
            exp_d_rdata <= '0;
            if (!ref_init) begin
                for (int i = 0; i < 64; i++) ref_mem[i] <= mem_init(i);
                ref_init <= 1'b1;
            end
        end else if (!mdl_busy) begin
            if (c_req || d_req) begin
                mdl_busy    <= 1'b1;
                mdl_age     <= 0;
                mdl_owner_d <= pick_d(c_req, d_req, last_served);
                mdl_we      <= pick_d(c_req, d_req, last_served) ? d_we    : c_we;
                mdl_addr    <= pick_d(c_req, d_req, last_served) ? d_addr  : c_addr;
                mdl_wdata   <= pick_d(c_req, d_req, last_served) ? d_wdata : c_wdata;
            end
        end else begin
            mdl_age <= mdl_age + 1;
            if (mdl_age == MEM_LAT - 1) begin
                if (mdl_we) ref_mem[mdl_addr[7:2]] <= mdl_wdata;
                else if (mdl_owner_d) exp_d_rdata <= ref_mem[mdl_addr[7:2]];
                else exp_c_rdata <= ref_mem[mdl_addr[7:2]];
                last_served <= mdl_owner_d ? 2 : 1;
            end else if (mdl_age == MEM_LAT) begin
                mdl_busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------- compare process
    always @(negedge clock) begin
        logic in_mem, done_c, done_d;
        in_mem = mdl_busy && (mdl_age < MEM_LAT);
        done_c = mdl_busy && (mdl_age == MEM_LAT) && !mdl_owner_d;
        done_d = mdl_busy && (mdl_age == MEM_LAT) && mdl_owner_d;
        check("m_re",    m_re,    in_mem & ~mdl_we);
        check("m_we",    m_we,    in_mem & mdl_we);
        check("m_addr",  m_addr,  in_mem ? mdl_addr  : '0);
        check("m_wdata", m_wdata, in_mem ? mdl_wdata : '0);
        check("c_done",  c_done,  done_c);
        check("d_done",  d_done,  done_d);
        check("c_rdata", c_rdata, exp_c_rdata);
        check("d_rdata", d_rdata, exp_d_rdata);
        check("c_stall", c_stall, c_req & ~done_c);
        check("d_stall", d_stall, d_req & ~done_d);
    end

    // -------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        int n_we, n_acc, n_cd, n_dd;
        logic [DW-1:0] got;
        int ev_port [$];
        int ev_cyc  [$];
        logic [31:0] r;

        // reset state
        repeat (2) tick();
        check("rst_m_re",    m_re,    1'b0);
        check("rst_m_we",    m_we,    1'b0);
        check("rst_c_done",  c_done,  1'b0);
        check("rst_c_rdata", c_rdata, 32'h0);
        reset_n = 1'b1;
        tick();

        // reset in the middle of a BUSY write
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h44; c_wdata = 32'hCAFEF00D;
        tick();
        check("t1_we_busy", m_we, 1'b1);
        #1 reset_n = 1'b0; c_req = 1'b0;
        #1 check("t1_we_async", m_we, 1'b0);
        check("t1_re_async", m_re, 1'b0);
        #3 reset_n = 1'b1;
        tick();
        check("t1_c_done",   c_done,      1'b0);
        check("t1_d_done",   d_done,      1'b0);
        check("t1_c_rdata",  c_rdata,     32'h0);
        check("t1_no_write", dev_mem[17], 32'hA5A50011);

        // core read of 0x40: grant at edge 1, done in cycle 3
        c_we = 1'b0; c_addr = 32'h40; c_req = 1'b1;
        #1 check("t2_stall_c0", c_stall, 1'b1);
        tick();
        check("t2_re_c1",    m_re,   1'b1);
        check("t2_stall_c1", c_stall, 1'b1);
        tick();
        check("t2_re_c2",    m_re,   1'b1);
        check("t2_done_c2",  c_done, 1'b0);
        tick();
        check("t2_done_c3",  c_done,  1'b1);
        check("t2_rdata",    c_rdata, 32'hDEADBEEF);
        check("t2_stall_c3", c_stall, 1'b0);
        check("t2_re_c3",    m_re,    1'b0);
        c_req = 1'b0;
        tick();
        check("t2_done_c4",  c_done, 1'b0);

        // DMA write 0x80, then core read-back
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678;
        n_we = 0; n_dd = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_we) n_we++;
            if (d_done) begin n_dd++; d_req = 1'b0; end
        end
        check("t4_we_cycles", n_we, MEM_LAT);
        check("t4_d_dones",   n_dd, 1);
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h80;
        got = '0; n_cd = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (c_done) begin n_cd++; got = c_rdata; c_req = 1'b0; end
        end
        check("t4_readback", got,  32'h12345678);
        check("t4_c_dones",  n_cd, 1);

        // core drops req in the first BUSY cycle of a write
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h44; c_wdata = 32'h0BADF00D;
        tick();
        n_acc = (m_we || m_re) ? 1 : 0;
        c_req = 1'b0;
        n_cd = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_we || m_re) n_acc++;
            if (c_done) n_cd++;
        end
        check("t5_c_dones",  n_cd, 1);
        check("t5_mem_cyc",  n_acc, MEM_LAT);
        check("t5_landed",   dev_mem[17], 32'h0BADF00D);

        // both reads held high from reset
        reset_n = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        #5 reset_n = 1'b1;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            tick();
            if (c_done) begin ev_port.push_back(0); ev_cyc.push_back(cyc); end
            if (d_done) begin ev_port.push_back(1); ev_cyc.push_back(cyc); end
        end
        check("t3_n_dones", (ev_port.size() >= 4), 1'b1);
        if (ev_port.size() >= 4) begin
            check("t3_first_cyc", ev_cyc[0], 3);
            for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
                check("t3_grant_order", ev_port[k], 0);
`else
                check("t3_grant_order", ev_port[k], k % 2);
`endif
                if (k > 0) check("t3_spacing", ev_cyc[k] - ev_cyc[k-1], MEM_LAT + 2);
            end
        end

        // both held for 20 more cycles: starvation under fixed priority
        n_cd = 0; n_dd = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (c_done) n_cd++;
            if (d_done) n_dd++;
        end
        check("t6_c_served", (n_cd >= 2), 1'b1);
`ifdef ARB_FIXED_PRIO_EN
        check("t6_d_starved", n_dd, 0);
`else
        check("t6_d_served", (n_dd >= 2), 1'b1);
`endif
        c_req = 1'b0; d_req = 1'b0;
        repeat (8) tick();

        // randomized traffic
        for (int i = 0; i < 700; i++) begin
            tick();
            r = $urandom();
            if (c_req && c_done) begin
                if (r[0]) c_req = 1'b0;
                else begin c_we = r[1]; c_addr = $urandom(); c_wdata = $urandom(); end
            end else if (!c_req) begin
                if (r[4:2] < 3) begin
                    c_req = 1'b1; c_we = r[1]; c_addr = $urandom(); c_wdata = $urandom();
                end
            end else if (r[15:10] == 0) begin
                c_req = 1'b0;
            end
            if (d_req && d_done) begin
                if (r[16]) d_req = 1'b0;
                else begin d_we = r[17]; d_addr = $urandom(); d_wdata = $urandom(); end
            end else if (!d_req) begin
                if (r[20:18] < 3) begin
                    d_req = 1'b1; d_we = r[17]; d_addr = $urandom(); d_wdata = $urandom();
                end
            end else if (r[31:26] == 0) begin
                d_req = 1'b0;
            end
        end
        c_req = 1'b0; d_req = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
